// File: rtl/ultrasonido_filtro.sv
// ============================================================================
// Module      : ultrasonido_filtro
// Description : Moving-average filter for ultrasonic distance samples. Drives a
//               proximity flag with hysteresis and a stale flag for a silent sensor.
//               Optional macro ULTRASONIDO_MEDIAN3_EN adds a 3-tap median prefilter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ultrasonido_filtro #(
  parameter int LOG2_N      = 3,
  parameter int THR_NEAR    = 30,
  parameter int THR_FAR     = 40,
  parameter int TIMEOUT_CYC = 6000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done_in,
  input  logic [15:0] distance_in,
  output logic [15:0] avg_distance,
  output logic        avg_valid,
  output logic        filled,
  output logic        near,
  output logic        stale
);

  localparam int N      = 1 << LOG2_N;
  localparam int SUM_W  = 16 + LOG2_N;
  localparam int FILL_W = LOG2_N + 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [FILL_W-1:0] c_n           = FILL_W'(N);
  localparam logic [15:0]       c_thr_near    = 16'(THR_NEAR);
  localparam logic [15:0]       c_thr_far     = 16'(THR_FAR);
  localparam logic [CNT_W-1:0]  c_timeout     = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  c_timeout_m1  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALE = 1'b1
  } state_t;

  logic              r_done_d;
  logic              r_cap_valid;
  logic [15:0]       r_cap_data;
  logic              w_capture;

  logic              w_buf_valid;
  logic [15:0]       w_buf_data;

  logic [15:0]       r_buf [N];
  logic [LOG2_N-1:0] r_wr_ptr;
  logic [SUM_W-1:0]  r_sum;
  logic [FILL_W-1:0] r_fill;
  logic              r_s1_valid;
  logic [15:0]       w_avg;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;

  assign w_capture = done_in & ~r_done_d;
  assign w_avg     = 16'(r_sum >> LOG2_N);

  // Capture stage: one sample per rising edge of done_in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done_d    <= 1'b0;
      r_cap_valid <= 1'b0;
      r_cap_data  <= '0;
    end else begin
      r_done_d    <= done_in;
      r_cap_valid <= w_capture;
      if (w_capture) begin
        r_cap_data <= distance_in;
      end
    end
  end

`ifdef ULTRASONIDO_MEDIAN3_EN
  logic [15:0] r_tap0;
  logic [15:0] r_tap1;
  logic        r_med_valid;
  logic [15:0] r_med_data;

  function automatic logic [15:0] med3(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  // Median over the newest capture and the two before it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tap0      <= '0;
      r_tap1      <= '0;
      r_med_valid <= 1'b0;
      r_med_data  <= '0;
    end else begin
      r_med_valid <= r_cap_valid;
      if (r_cap_valid) begin
        r_med_data <= med3(r_cap_data, r_tap0, r_tap1);
        r_tap0     <= r_cap_data;
        r_tap1     <= r_tap0;
      end
    end
  end

  assign w_buf_valid = r_med_valid;
  assign w_buf_data  = r_med_data;
`else
  assign w_buf_valid = r_cap_valid;
  assign w_buf_data  = r_cap_data;
`endif

  // Circular buffer with running sum; the sum is wide enough for N full-scale entries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_sum      <= '0;
      r_fill     <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_buf_valid;
      if (w_buf_valid) begin
        r_buf[r_wr_ptr] <= w_buf_data;
        r_sum           <= r_sum + SUM_W'(w_buf_data) - SUM_W'(r_buf[r_wr_ptr]);
        r_wr_ptr        <= r_wr_ptr + LOG2_N'(1);
        if (r_fill != c_n) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
    end
  end

  // Output stage: average, valid pulse and hysteresis only once the window is full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avg_distance <= '0;
      avg_valid    <= 1'b0;
      filled       <= 1'b0;
      near         <= 1'b0;
    end else begin
      filled    <= (r_fill == c_n);
      avg_valid <= r_s1_valid && (r_fill == c_n);
      if (r_s1_valid && (r_fill == c_n)) begin
        avg_distance <= w_avg;
        if (!near && (w_avg < c_thr_near)) begin
          near <= 1'b1;
        end else if (near && (w_avg >= c_thr_far)) begin
          near <= 1'b0;
        end
      end
    end
  end

  // Silence watchdog; a capture edge takes priority over expiry in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      stale   <= 1'b0;
    end else if (w_capture) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      stale   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_cnt == c_timeout_m1) begin
            r_cnt   <= c_timeout;
            stale   <= 1'b1;
            r_state <= ST_STALE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STALE: begin
          stale <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ultrasonido_filtro.sv
// Scoreboard bench for ultrasonido_filtro: expected averages are queued at stimulus time
// and popped by a monitor whenever avg_valid pulses.
`default_nettype none

module tb_ultrasonido_filtro;

  localparam int TO = 100;
`ifdef ULTRASONIDO_MEDIAN3_EN
  localparam int LAT    = 3;
  localparam int T_AVG1 = 52;
  localparam int C_AVG  = 43;
`else
  localparam int LAT    = 2;
  localparam int T_AVG1 = 60;
  localparam int C_AVG  = 50;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        done_in = 1'b0;
  logic [15:0] distance_in = '0;
  logic [15:0] avg_distance;
  logic        avg_valid;
  logic        filled;
  logic        near;
  logic        stale;

  ultrasonido_filtro #(
    .LOG2_N(3), .THR_NEAR(30), .THR_FAR(40), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .done_in(done_in), .distance_in(distance_in),
    .avg_distance(avg_distance), .avg_valid(avg_valid), .filled(filled),
    .near(near), .stale(stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int avg;
    bit nr;
    int at;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  int tbl35[8] = '{21, 23, 25, 27, 29, 31, 33, 35};
  int tbl45[4] = '{36, 37, 38, 40};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every avg_valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset && avg_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got avg %0d at cycle %0d, expected no pulse",
                 avg_distance, cyc);
      end else begin
        e = q.pop_front();
        check("avg", int'(avg_distance), e.avg);
        check("near", int'(near), int'(e.nr));
        check("latency", cyc, e.at);
        check("filled", int'(filled), 1);
      end
    end
  end

  task automatic sample(input logic [15:0] d, input bit pulse, input int eavg, input bit enear);
    @(negedge clk);
    done_in = 1'b1;
    distance_in = d;
    if (pulse) q.push_back('{eavg, enear, cyc + 1 + LAT});
    @(negedge clk);
    done_in = 1'b0;
    distance_in = 16'hBEEF;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_avg"}, int'(avg_distance), 0);
    check({tag, "_valid"}, int'(avg_valid), 0);
    check({tag, "_filled"}, int'(filled), 0);
    check({tag, "_near"}, int'(near), 0);
    check({tag, "_stale"}, int'(stale), 0);
  endtask

  task automatic do_reset();
    repeat (6) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("rst");
    reset = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("por");
    reset = 1'b1;

`ifndef ULTRASONIDO_MEDIAN3_EN
    // Fill with 100, then entry and exit hysteresis
    for (int i = 1; i <= 7; i++) sample(16'd100, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("filled_before_8th", int'(filled), 0);
    sample(16'd100, 1'b1, 100, 1'b0);
    for (int i = 1; i <= 8; i++) sample(16'd20, 1'b1, 100 - 10 * i, (i == 8));
    for (int i = 0; i < 8; i++) sample(16'd35, 1'b1, tbl35[i], 1'b1);
    for (int i = 0; i < 4; i++) sample(16'd45, 1'b1, tbl45[i], (i != 3));
`else
    // Spike rejection; first median output is 0 because the taps start cleared
    for (int i = 1; i <= 10; i++) sample(16'd10, (i >= 8), (i == 8) ? 8 : 10, 1'b1);
    sample(16'd900, 1'b1, 10, 1'b1);
    for (int i = 1; i <= 5; i++) sample(16'd10, 1'b1, 10, 1'b1);
`endif

    // Held level gives one sample; stale after TO idle cycles
    do_reset();
    for (int i = 1; i <= 7; i++) sample(16'd60, 1'b0, 0, 1'b0);
    @(negedge clk);
    done_in = 1'b1;
    distance_in = 16'd60;
    q.push_back('{T_AVG1, 1'b0, cyc + 1 + LAT});
    @(negedge clk);
    check("stale_at_edge", int'(stale), 0);
    repeat (TO - 1) @(negedge clk);
    check("stale_before_timeout", int'(stale), 0);
    @(negedge clk);
    check("stale_at_timeout", int'(stale), 1);
    repeat (500 - TO - 1) @(negedge clk);
    check("stale_held", int'(stale), 1);
    done_in = 1'b0;
    @(negedge clk);
    check("stale_before_new_edge", int'(stale), 1);
    done_in = 1'b1;
    distance_in = 16'd60;
    q.push_back('{60, 1'b0, cyc + 1 + LAT});
    @(negedge clk);
    check("stale_cleared_by_edge", int'(stale), 0);
    done_in = 1'b0;

    // Reset between capture and buffer write discards the pending sample
    do_reset();
    for (int i = 1; i <= 4; i++) sample(16'd200, 1'b0, 0, 1'b0);
    @(negedge clk);
    done_in = 1'b1;
    distance_in = 16'd200;
    @(posedge clk);
    #2;
    reset = 1'b0;
    done_in = 1'b0;
    #1;
    check_zero("async");
    repeat (2) @(negedge clk);
    check_zero("hold");
    reset = 1'b1;
    done_in = 1'b1;
    distance_in = 16'd50;
    @(negedge clk);
    done_in = 1'b0;
    for (int i = 2; i <= 8; i++) sample(16'd50, (i == 8), C_AVG, 1'b0);

    repeat (8) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
